tlb_walker: RTL and testbench

- Hardware page-table walker directly upstream of the 8-entry TLB; services a TLB miss instead of trapping to software.
- Accepts a miss key {pid[11:0], vpn[19:0]}, performs a two-level page-table walk over a physical-memory read port, then drives the TLB write port (we, read_addr=key, write_data[5:0]=ppn).
- Reports completion, or a page fault to the exception path.

---
 rtl/dioptase_mmu_pkg.sv | 29 ++
 rtl/tlb_walker.sv | 123 ++++++++++++
 tb/tb_tlb_walker.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dioptase_mmu_pkg.sv
// Shared MMU definitions: page-table walker states, PTE field layout,
// TLB key layout and exception codes.
package dioptase_mmu_pkg;

    typedef enum logic [2:0] {
        WALK_IDLE,
        WALK_L1_REQ,
        WALK_L1_WAIT,
        WALK_L2_REQ,
        WALK_L2_WAIT,
        WALK_FILL,
        WALK_FAULT
    } walk_state_t;

    localparam int PTE_VALID_BIT = 0;
    localparam int PTE_PPN_MSB   = 17;
    localparam int PTE_PPN_LSB   = 12;

    localparam logic [7:0] EXC_UMISS      = 8'h82;
    localparam logic [7:0] EXC_KMISS      = 8'h83;
    localparam logic [7:0] EXC_PAGE_FAULT = 8'h84;

    localparam int PID_W     = 12;
    localparam int VPN_W     = 20;
    localparam int KEY_W     = PID_W + VPN_W;
    // Each table level is indexed by half of the vpn.
    localparam int LVL_IDX_W = VPN_W / 2;

endpackage

// File: rtl/tlb_walker.sv
// Two-level hardware page-table walker: turns a TLB miss into PTE reads and
// either a single TLB fill or a page-fault pulse.
module tlb_walker
    import dioptase_mmu_pkg::*;
#(
    parameter int         PA_W       = 18,
    parameter int         PPN_W      = 6,
    parameter logic [7:0] FAULT_CODE = EXC_PAGE_FAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [PA_W-1:0]  ptbr,
    input  logic             clear,
    input  logic             miss_valid,
    input  logic [KEY_W-1:0] miss_key,
    output logic             miss_ready,
    output logic             mem_req,
    output logic [PA_W-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             tlb_we,
    output logic [KEY_W-1:0] tlb_key,
    output logic [31:0]      tlb_data,
    output logic             done,
    output logic             fault,
    output logic [7:0]       fault_code
);

    walk_state_t          state_q, state_d;
    logic [KEY_W-1:0]     key_q;
    logic [PPN_W-1:0]     ppn_q;
    logic [LVL_IDX_W-1:0] l1_idx, l2_idx;
    logic                 pte_valid;
    logic                 pte_take;
    logic                 unused_bits;

    assign l1_idx    = key_q[VPN_W-1 -: LVL_IDX_W];
    assign l2_idx    = key_q[LVL_IDX_W-1:0];
    assign pte_valid = mem_rdata[PTE_VALID_BIT];
    assign pte_take  = mem_ack && (state_q == WALK_L1_WAIT || state_q == WALK_L2_WAIT);
    assign unused_bits = ^{ptbr[PA_W-PPN_W-1:0], mem_rdata[31:PTE_PPN_MSB+1],
                           mem_rdata[PTE_PPN_LSB-1:PTE_VALID_BIT+1]};

    // clear aborts from any state, but like everything else only on an enabled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WALK_IDLE;
        end else if (clk_en) begin
            state_q <= clear ? WALK_IDLE : state_d;
        end
    end

    // Key and ppn are only observed in states reached after they are written,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (clk_en && !clear) begin
            if (state_q == WALK_IDLE && miss_valid) begin
                key_q <= miss_key;
            end
            if (pte_take) begin
                ppn_q <= mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        miss_ready = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        tlb_we     = 1'b0;
        tlb_key    = '0;
        tlb_data   = '0;
        done       = 1'b0;
        fault      = 1'b0;
        fault_code = 8'h00;

        case (state_q)
            WALK_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    state_d = WALK_L1_REQ;
                end
            end
            WALK_L1_REQ, WALK_L1_WAIT: begin
                mem_req  = !clear;
                mem_addr = {ptbr[PA_W-1 -: PPN_W], l1_idx, 2'b00};
                if (state_q == WALK_L1_REQ) begin
                    state_d = WALK_L1_WAIT;
                end else if (mem_ack) begin
                    state_d = pte_valid ? WALK_L2_REQ : WALK_FAULT;
                end
            end
            WALK_L2_REQ, WALK_L2_WAIT: begin
                mem_req  = !clear;
                mem_addr = {ppn_q, l2_idx, 2'b00};
                if (state_q == WALK_L2_REQ) begin
                    state_d = WALK_L2_WAIT;
                end else if (mem_ack) begin
                    state_d = pte_valid ? WALK_FILL : WALK_FAULT;
                end
            end
            WALK_FILL: begin
                // A clear arriving with the fill wins; the entry is never written.
                tlb_we   = !clear;
                done     = !clear;
                tlb_key  = key_q;
                tlb_data = {{(32-PPN_W){1'b0}}, ppn_q};
                state_d  = WALK_IDLE;
            end
            WALK_FAULT: begin
                fault      = !clear;
                fault_code = clear ? 8'h00 : FAULT_CODE;
                state_d    = WALK_IDLE;
            end
            default: begin
                state_d = WALK_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tlb_walker.sv
// Self-checking bench for tlb_walker: directed walks plus randomized traffic
// compared every cycle against a transaction-level model of the walk.
module tb_tlb_walker;

    logic        clk = 1'b0;
    logic        rst, clk_en, clear, miss_valid, miss_ready, mem_req, mem_ack;
    logic        tlb_we, done, fault;
    logic [17:0] ptbr, mem_addr;
    logic [31:0] miss_key, mem_rdata, tlb_key, tlb_data;
    logic [7:0]  fault_code;

    tlb_walker dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ptbr(ptbr), .clear(clear),
        .miss_valid(miss_valid), .miss_key(miss_key), .miss_ready(miss_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .tlb_we(tlb_we), .tlb_key(tlb_key), .tlb_data(tlb_data),
        .done(done), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [int];

    // Model of one walk: busy flag, which table level is being read, whether the
    // read was issued this cycle (ack ignored), and the pending outcome pulse.
    bit          m_busy  = 0;
    bit          m_fresh = 0;
    bit          m_lvl   = 0;
    bit          m_acc   = 0;
    int          m_pulse = 0;
    logic [31:0] m_key   = '0;
    logic [5:0]  m_ppn   = '0;
    bit          walking;

    int lat  = 0;
    bit spur = 0;
    int wcnt = 0;

    int          cyc, nwe, ndone, nfault, nreq_cyc, we_cyc;
    logic [31:0] kw, dw;
    logic [7:0]  fc;
    logic [17:0] addrs[$];
    logic        prev_req  = 1'b0;
    logic [17:0] prev_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] exp_addr();
        if (m_lvl) return {m_ppn, m_key[9:0], 2'b00};
        return {ptbr[17:12], m_key[19:10], 2'b00};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [17:0] a);
        logic [31:0] v;
        if (!mem.exists(int'(a))) begin
            v    = $urandom;
            v[0] = ($urandom_range(0, 9) != 0);
            mem[int'(a)] = v;
        end
        return mem[int'(a)];
    endfunction

    // Reference model update on every edge, comparison at the following negedge.
    initial forever begin
        @(posedge clk);
        m_acc = 0;
        if (rst) begin
            m_busy = 0; m_pulse = 0; m_fresh = 0;
        end else if (clk_en) begin
            if (clear) begin
                m_busy = 0; m_pulse = 0;
            end else if (m_pulse != 0) begin
                m_busy = 0; m_pulse = 0;
            end else if (!m_busy) begin
                if (miss_valid) begin
                    m_busy = 1; m_key = miss_key; m_lvl = 0; m_fresh = 1; m_acc = 1;
                end
            end else if (m_fresh) begin
                m_fresh = 0;
            end else if (mem_ack) begin
                if (!mem_rdata[0]) m_pulse = 2;
                else begin
                    m_ppn = mem_rdata[17:12];
                    if (!m_lvl) begin m_lvl = 1; m_fresh = 1; end
                    else m_pulse = 1;
                end
            end
        end
        @(negedge clk);
        walking = m_busy && (m_pulse == 0);
        chk("miss_ready", 32'(miss_ready), 32'(!m_busy));
        chk("mem_req",    32'(mem_req),    32'(walking && !clear));
        chk("mem_addr",   32'(mem_addr),   32'(walking ? exp_addr() : 18'h0));
        chk("tlb_we",     32'(tlb_we),     32'(m_pulse == 1 && !clear));
        chk("done",       32'(done),       32'(m_pulse == 1 && !clear));
        chk("tlb_key",    tlb_key,         (m_pulse == 1) ? m_key : 32'h0);
        chk("tlb_data",   tlb_data,        (m_pulse == 1) ? {26'b0, m_ppn} : 32'h0);
        chk("fault",      32'(fault),      32'(m_pulse == 2 && !clear));
        chk("fault_code", 32'(fault_code), (m_pulse == 2 && !clear) ? 32'h84 : 32'h0);
    end

    // Memory responder: acks only once a read is in its wait phase, after lat enabled cycles.
    initial begin
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (m_busy && m_pulse == 0 && !m_fresh) begin
                if (wcnt >= lat) begin
                    mem_ack = 1'b1; mem_rdata = mem_rd(mem_addr);
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                    if (clk_en) wcnt++;
                end
            end else begin
                wcnt = 0; mem_ack = spur; mem_rdata = $urandom;
            end
        end
    end

    // Transaction monitor for the directed tests.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (mem_req) nreq_cyc++;
        if (mem_req && (!prev_req || mem_addr != prev_addr)) addrs.push_back(mem_addr);
        prev_req = mem_req; prev_addr = mem_addr;
        if (tlb_we) begin nwe++; kw = tlb_key; dw = tlb_data; we_cyc = cyc; end
        if (done) ndone++;
        if (fault) begin nfault++; fc = fault_code; end
    end

    task automatic clear_stats();
        cyc = -1; nwe = 0; ndone = 0; nfault = 0; nreq_cyc = 0; we_cyc = -1;
        kw = '0; dw = '0; fc = '0;
        addrs.delete();
    endtask

    task automatic start_miss(input logic [31:0] key);
        clear_stats();
        miss_valid = 1'b1; miss_key = key;
        @(posedge clk); #1;
        miss_valid = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        while (ndone == 0 && nfault == 0 && n < 80) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 80) begin
            failures++;
            $display("FAIL %s timeout actual=no_pulse required=done_or_fault", nm);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; clear = 1'b0; miss_valid = 1'b0; miss_key = '0;
        ptbr = 18'h10000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(miss_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        @(posedge clk); #1;

        // Hit path, single-cycle ack.
        mem[32'h10004] = 32'h0000_2001;
        mem[32'h0200C] = 32'h0000_5001;
        lat = 0;
        start_miss(32'h0010_0403);
        wait_end("hit");
        chk("hit_nreq", addrs.size(), 2);
        if (addrs.size() == 2) begin
            chk("hit_addr_l1", 32'(addrs[0]), 32'h10004);
            chk("hit_addr_l2", 32'(addrs[1]), 32'h0200C);
        end
        chk("hit_we_cnt", nwe, 1);
        chk("hit_key", kw, 32'h0010_0403);
        chk("hit_data", dw, 32'h5);
        chk("hit_done", ndone, 1);
        chk("hit_fault", nfault, 0);
        chk("hit_latency", we_cyc, 5);
        chk("hit_req_cycles", nreq_cyc, 4);

        // L1 PTE invalid.
        mem[32'h10004] = 32'h0000_2000;
        start_miss(32'h0010_0403);
        wait_end("l1_inv");
        chk("l1_inv_fault", nfault, 1);
        chk("l1_inv_code", 32'(fc), 32'h84);
        chk("l1_inv_we", nwe, 0);
        chk("l1_inv_nreq", addrs.size(), 1);

        // L2 PTE invalid.
        mem[32'h10004] = 32'h0000_2001;
        mem[32'h0200C] = 32'h0000_0000;
        start_miss(32'h0010_0403);
        wait_end("l2_inv");
        chk("l2_inv_fault", nfault, 1);
        chk("l2_inv_we", nwe, 0);
        chk("l2_inv_done", ndone, 0);
        chk("l2_inv_nreq", addrs.size(), 2);

        // Spurious ack in IDLE, then 4-cycle memory latency per level.
        mem[32'h0200C] = 32'h0000_5001;
        spur = 1'b1;
        @(negedge clk);
        chk("spur_ready", 32'(miss_ready), 32'd1);
        chk("spur_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        chk("spur_after_ready", 32'(miss_ready), 32'd1);
        @(posedge clk); #1;
        lat = 4;
        start_miss(32'h0010_0403);
        wait_end("slow");
        chk("slow_nreq", addrs.size(), 2);
        chk("slow_req_cycles", nreq_cyc, 12);
        chk("slow_latency", we_cyc, 13);
        chk("slow_data", dw, 32'h5);

        // clear during L2_WAIT followed by a late ack, then a normal walk.
        lat = 2;
        start_miss(32'h0010_0403);
        begin
            int n = 0;
            while (!(mem_req && mem_addr == 18'h0200C) && n < 30) begin
                @(negedge clk); n++;
            end
            chk("clr_reach_l2", 32'(n < 30), 32'd1);
        end
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("clr_we", nwe, 0);
        chk("clr_done", ndone, 0);
        chk("clr_fault", nfault, 0);
        chk("clr_idle", 32'(miss_ready), 32'd1);
        start_miss(32'h0010_0403);
        wait_end("clr_next");
        chk("clr_next_we", nwe, 1);
        chk("clr_next_data", dw, 32'h5);

        // clk_en low for 3 cycles while waiting on the L1 read.
        lat = 2;
        start_miss(32'h0010_0403);
        @(posedge clk); #1;
        clk_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("frz_req", 32'(mem_req), 32'd1);
            chk("frz_addr", 32'(mem_addr), 32'h10004);
            chk("frz_ready", 32'(miss_ready), 32'd0);
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        wait_end("frz");
        chk("frz_we", nwe, 1);
        chk("frz_key", kw, 32'h0010_0403);
        chk("frz_data", dw, 32'h5);
        chk("frz_nreq", addrs.size(), 2);
        chk("frz_latency", we_cyc, 12);

        // rst on the edge that would register FILL.
        lat = 0;
        start_miss(32'h0010_0403);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_we", 32'(tlb_we), 32'd0);
        chk("rstw_done", 32'(done), 32'd0);
        chk("rstw_req", 32'(mem_req), 32'd0);
        chk("rstw_addr", 32'(mem_addr), 32'd0);
        chk("rstw_key", tlb_key, 32'd0);
        chk("rstw_data", tlb_data, 32'd0);
        chk("rstw_ready", 32'(miss_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rstw_we_total", nwe, 0);
        chk("rstw_fault_total", nfault, 0);

        // Randomized traffic against the model.
        ptbr = 18'($urandom);
        mem.delete();
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 399) == 0);
            clk_en = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 39) == 0);
            spur   = ($urandom_range(0, 15) == 0);
            lat    = $urandom_range(0, 3);
            if (miss_valid && m_acc) miss_valid = 1'b0;
            else if (!miss_valid && $urandom_range(0, 1) == 1) begin
                miss_valid = 1'b1;
                miss_key   = $urandom;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; clk_en = 1'b1; clear = 1'b0; spur = 1'b0; miss_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
